// File: rtl/spike_rate_decoder.sv
// Spike-train rate decoder: counts rising edges per programmable window, hands each
// window's count out on a valid/ready port, and tracks the latest inter-spike interval.
module spike_rate_decoder #(
  parameter int WINDOW_W = 8,
  parameter int COUNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                spike_in,
  input  logic [WINDOW_W-1:0] window_len,
  output logic [COUNT_W-1:0]  rate_out,
  output logic                rate_valid,
  input  logic                rate_ready,
  output logic                overrun,
  output logic [7:0]          isi_out,
  output logic                state_dbg
);

  // Handshake: a result transfers on any rising clk edge where rate_valid && rate_ready;
  // rate_out is held while rate_valid is high unless a newer window result replaces it.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state, state_nxt;
  logic                  spike_q;
  logic                  spike_edge;
  logic [WINDOW_W-1:0]   win_cnt;
  logic [WINDOW_W-1:0]   win_load;
  logic [COUNT_W-1:0]    count;
  logic [COUNT_W:0]      count_sum;
  logic [COUNT_W-1:0]    count_inc;
  logic [7:0]            isi_cnt;
  logic [7:0]            isi_inc;
  logic                  run_active;
  logic                  win_end;

  assign spike_edge = spike_in & ~spike_q;
  assign win_load   = (window_len == '0) ? WINDOW_W'(1) : window_len;
  assign count_sum  = {1'b0, count} + (COUNT_W+1)'(spike_edge);
  assign count_inc  = count_sum[COUNT_W] ? '1 : count_sum[COUNT_W-1:0];
  assign isi_inc    = (isi_cnt == 8'hff) ? 8'hff : isi_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ena)  state_nxt = RUN;
      RUN:     if (!ena) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    run_active = (state == RUN) && ena;
    win_end    = run_active && (win_cnt == WINDOW_W'(1));
    state_dbg  = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spike_q <= 1'b0;
    else        spike_q <= spike_in;
  end

  // Window and spike counters; leaving RUN drops the partial window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      count   <= '0;
    end else if (state == IDLE) begin
      win_cnt <= ena ? win_load : '0;
      count   <= '0;
    end else if (!ena) begin
      win_cnt <= '0;
      count   <= '0;
    end else if (win_end) begin
      win_cnt <= win_load;
      count   <= '0;
    end else begin
      win_cnt <= win_cnt - WINDOW_W'(1);
      count   <= count_inc;
    end
  end

  // isi_cnt of zero means no edge seen since entering RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_cnt <= '0;
      isi_out <= '0;
    end else if (!run_active) begin
      isi_cnt <= '0;
    end else if (spike_edge) begin
      if (isi_cnt != 8'd0) isi_out <= isi_cnt;
      isi_cnt <= 8'd1;
    end else if (isi_cnt != 8'd0) begin
      isi_cnt <= isi_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_out   <= '0;
      rate_valid <= 1'b0;
    end else if (win_end) begin
      rate_out   <= count_inc;
      rate_valid <= 1'b1;
    end else if (rate_valid && rate_ready) begin
      rate_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     overrun <= 1'b0;
    else if (state == IDLE)                         overrun <= 1'b0;
    else if (win_end && rate_valid && !rate_ready)  overrun <= 1'b1;
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: window counting, saturation, handshake/overrun,
// inter-spike interval and reset behaviour, with hand-computed expectations.
module tb_spike_rate_decoder;

  logic        clk;
  logic        rst_n;
  logic        ena, spike_in, rate_ready;
  logic [7:0]  window_len;
  logic [7:0]  rate_out;
  logic        rate_valid, overrun, state_dbg;
  logic [7:0]  isi_out;

  logic        ena2, spike2;
  logic [9:0]  window_len2;
  logic [7:0]  rate_out2;
  logic        rate_valid2, overrun2, state_dbg2;
  logic [7:0]  isi_out2;

  int n_checks = 0;
  int n_errors = 0;

  spike_rate_decoder dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in), .window_len(window_len),
    .rate_out(rate_out), .rate_valid(rate_valid), .rate_ready(rate_ready),
    .overrun(overrun), .isi_out(isi_out), .state_dbg(state_dbg)
  );

  spike_rate_decoder #(.WINDOW_W(10), .COUNT_W(8)) dut_wide (
    .clk(clk), .rst_n(rst_n), .ena(ena2), .spike_in(spike2), .window_len(window_len2),
    .rate_out(rate_out2), .rate_valid(rate_valid2), .rate_ready(1'b0),
    .overrun(overrun2), .isi_out(isi_out2), .state_dbg(state_dbg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    ena = 1'b0;
    step();
    step();
  endtask

  initial begin
    logic [4:0] pat6;
    logic [4:0] exp6;
    rst_n = 1'b0; ena = 1'b0; spike_in = 1'b0; rate_ready = 1'b0; window_len = 8'd10;
    ena2 = 1'b0; spike2 = 1'b0; window_len2 = 10'd600;
    #12;
    check("reset_rate_out", rate_out, 0);
    check("reset_valid", rate_valid, 0);
    check("reset_overrun", overrun, 0);
    check("reset_isi", isi_out, 0);
    check("reset_state", state_dbg, 0);
    check("reset_wide_rate", rate_out2, 0);
    rst_n = 1'b1;
    step();

    // One spike every two cycles over a 10-cycle window.
    ena = 1'b1;
    step();
    check("run_entered", state_dbg, 1);
    for (int i = 1; i <= 10; i++) begin
      spike_in = i[0];
      step();
      if (i == 9) check("alt_not_yet_valid", rate_valid, 0);
    end
    check("alt_rate", rate_out, 5);
    check("alt_valid", rate_valid, 1);
    check("alt_isi", isi_out, 2);
    rate_ready = 1'b1;
    spike_in = 1'b0;
    step();
    check("alt_taken", rate_valid, 0);
    go_idle();
    check("back_idle", state_dbg, 0);

    // Level held high counts once; following window counts zero.
    ena = 1'b1;
    step();
    spike_in = 1'b1;
    for (int i = 1; i <= 10; i++) step();
    check("held_rate", rate_out, 1);
    check("held_valid", rate_valid, 1);
    for (int i = 11; i <= 20; i++) step();
    check("held_next_rate", rate_out, 0);
    check("held_next_valid", rate_valid, 1);
    check("held_overrun", overrun, 0);
    spike_in = 1'b0;
    go_idle();

    // 600-cycle window on the wide instance: 300 edges saturate at 255.
    ena2 = 1'b1;
    step();
    for (int i = 1; i <= 600; i++) begin
      spike2 = i[0];
      step();
    end
    check("sat_rate", rate_out2, 255);
    check("sat_valid", rate_valid2, 1);
    check("sat_overrun", overrun2, 0);
    ena2 = 1'b0;

    // Two window ends without ready: overwrite and sticky overrun.
    window_len = 8'd4;
    rate_ready = 1'b0;
    ena = 1'b1;
    step();
    for (int i = 1; i <= 8; i++) begin
      spike_in = (i == 1 || i == 5 || i == 7);
      step();
      if (i == 4) check("ovr_first_rate", rate_out, 1);
    end
    check("ovr_second_rate", rate_out, 2);
    check("ovr_flag", overrun, 1);
    check("ovr_valid", rate_valid, 1);
    spike_in = 1'b0;
    go_idle();
    check("ovr_cleared_idle", overrun, 0);
    check("ovr_pending_valid", rate_valid, 1);
    check("ovr_pending_rate", rate_out, 2);
    rate_ready = 1'b1;
    step();
    check("ovr_taken_idle", rate_valid, 0);

    // Ready arriving exactly at the second window end: no overrun.
    rate_ready = 1'b0;
    ena = 1'b1;
    step();
    for (int i = 1; i <= 8; i++) begin
      spike_in = (i == 1 || i == 5 || i == 7);
      rate_ready = (i == 8);
      step();
    end
    check("sim_rate", rate_out, 2);
    check("sim_valid", rate_valid, 1);
    check("sim_overrun", overrun, 0);
    spike_in = 1'b0;
    ena = 1'b0;
    step();
    check("sim_taken", rate_valid, 0);
    step();
    check("isi_before", isi_out, 2);

    // ISI: first edge leaves isi_out, 3-cycle spacing, then a long gap saturates.
    window_len = 8'd255;
    rate_ready = 1'b1;
    ena = 1'b1;
    step();
    spike_in = 1'b1;
    step();
    check("isi_first_edge", isi_out, 2);
    for (int i = 2; i <= 7; i++) begin
      spike_in = (i == 4 || i == 7);
      step();
      if (i == 4) check("isi_three_a", isi_out, 3);
    end
    check("isi_three_b", isi_out, 3);
    spike_in = 1'b0;
    for (int i = 8; i <= 307; i++) step();
    spike_in = 1'b1;
    step();
    check("isi_saturated", isi_out, 255);
    spike_in = 1'b0;
    go_idle();

    // window_len 0: one result per cycle equal to the edge.
    window_len = 8'd0;
    ena = 1'b1;
    step();
    pat6 = 5'b01101;
    exp6 = 5'b00101;
    for (int i = 0; i < 5; i++) begin
      spike_in = pat6[i];
      step();
      check($sformatf("w0_rate_%0d", i), rate_out, {7'd0, exp6[i]});
      check($sformatf("w0_valid_%0d", i), rate_valid, 1);
    end

    // Asynchronous reset mid-window clears everything with no result afterwards.
    window_len = 8'd10;
    rate_ready = 1'b0;
    spike_in = 1'b1;
    step();
    spike_in = 1'b0;
    step(); step(); step();
    check("pre_reset_rate", rate_out, 1);
    check("pre_reset_isi", isi_out, 3);
    #1 rst_n = 1'b0;
    #1;
    check("async_rate_out", rate_out, 0);
    check("async_valid", rate_valid, 0);
    check("async_isi", isi_out, 0);
    check("async_state", state_dbg, 0);
    ena = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      spike_in = i[0];
      step();
    end
    check("post_reset_valid", rate_valid, 0);
    check("post_reset_rate", rate_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Receive-side counterpart of the spiking neuron: converts a spike train back into a binary rate value. Counts rising edges on a spike line over a programmable window of clock cycles, presents each window's count on a valid/ready output port, and measures the most recent inter-spike interval. Sits downstream of the neuron's spike output, feeding readout logic or the bidirectional output pins of the top level.

## Interface

Parameters:
- WINDOW_W, 8, width of the window-length input and window down-counter
- COUNT_W, 8, width of the spike count and rate_out; count saturates at 2^COUNT_W-1

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  decode enable; low forces IDLE
- spike_in  input  1  spike line, synchronous to clk
- window_len  input  WINDOW_W  window length in cycles; 0 treated as 1
- rate_out  output  COUNT_W  spike count of last completed window
- rate_valid  output  1  rate_out holds an untaken result
- rate_ready  input  1  consumer accepts rate_out when high with rate_valid
- overrun  output  1  sticky: a result was overwritten before being taken
- isi_out  output  8  cycles between the two most recent rising edges, saturating at 255

## Operation

- Edge detect: spike_q <= spike_in every cycle, in every state; edge = spike_in & ~spike_q. Only edges count; a level held high counts once.
- States: IDLE, RUN.
  - IDLE: window counter, spike count, ISI counter held at 0. ena=1 -> RUN, window counter <= (window_len==0 ? 1 : window_len).
  - RUN: ena=0 -> IDLE; partial window discarded, no result produced. Otherwise each cycle: count <= sat(count + edge); window counter decrements.
  - Window end (window counter==1 in RUN): result = sat(count + edge) loaded into rate_out, rate_valid <= 1; count <= 0; window counter reloaded from window_len (sampled this cycle, 0 -> 1).
- Output handshake: transfer when rate_valid & rate_ready. rate_out stable while rate_valid=1 and no new result. Transfer without new result -> rate_valid <= 0. New result in same cycle as transfer -> rate_valid stays 1, no overrun. New result while rate_valid=1 and rate_ready=0 -> rate_out overwritten, overrun <= 1.
- overrun cleared only by reset or while in IDLE.
- Pending result survives RUN->IDLE; handshake continues in IDLE.
- ISI: 8-bit isi_cnt, 0 = no previous edge since entering RUN. In RUN: edge -> if isi_cnt!=0, isi_out <= isi_cnt; isi_cnt <= 1. No edge -> isi_cnt <= (isi_cnt==0 ? 0 : sat255(isi_cnt+1)). Edges at cycles t1, t2 give isi_out = min(t2-t1, 255). First edge after entering RUN does not update isi_out. IDLE clears isi_cnt, holds isi_out.
- All arithmetic saturating; no counter wraps.

## Timing

- Reset (rst_n low, asynchronous): state IDLE, spike_q=0, rate_out=0, rate_valid=0, overrun=0, isi_out=0, all counters 0. Reset mid-window aborts the window with no result.
- ena sampled high at edge E0 in IDLE -> RUN at E0. Window of length N samples spike_in at edges E1..EN. rate_out/rate_valid update at EN; next window covers E(N+1)..E(2N) with no gap.
- Result latency: visible the cycle after the last sampled edge of the window.
- isi_out updates at the same edge that samples the second rising edge.
- rate_ready is combinationally unused; all outputs are registered.

## Test plan

- window_len=10, spike_in high one cycle in every two from E1 -> rate_out=5, rate_valid=1 after E10; rate_ready=1 -> rate_valid=0 next cycle.
- spike_in held high through a window of 10 -> rate_out=1 (edge only); next window rate_out=0.
- WINDOW_W=10, window_len=600, spike_in alternating -> rate_out=255 (saturated), no wrap.
- rate_ready=0 across two window ends -> second count in rate_out, overrun=1; ready at exactly the second window end instead -> rate_valid stays 1, overrun=0; ena low -> overrun=0.
- Edges spaced 3 cycles, then a 300-cycle gap -> isi_out=3, then 255; first edge after enabling leaves isi_out unchanged.
- window_len=0 -> one result per cycle equal to edge; rst_n low mid-window -> all outputs 0 immediately, no result on release.
